fir_serial_mac: RTL and testbench

- Time-multiplexed FIR filter stage. It sits downstream of the enable-gated sample registers (dflopie) that form the input path.
- Accepts one signed sample per handshake and stores it in an NTAPS-deep circular history buffer.
- Computes y[n] = sum over k of c[k]·x[n−k] using one multiplier over NTAPS cycles, then presents the full-precision result on a valid/ready output.

---
 rtl/fir_serial_mac.sv | 116 +++++++++++
 tb/tb_fir_serial_mac.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fir_serial_mac.sv
// Time-multiplexed FIR stage: one sample per handshake, one multiply per cycle
// over NTAPS cycles, full-precision result on a valid/ready output.
module fir_serial_mac #(
  parameter int unsigned DW    = 16,
  parameter int unsigned CW    = 16,
  parameter int unsigned NTAPS = 8,
  localparam int unsigned KW   = $clog2(NTAPS),
  localparam int unsigned AW   = DW + CW + $clog2(NTAPS)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          en_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] data_in,
  input  logic          coef_we_i,
  input  logic [KW-1:0] coef_addr_i,
  input  logic [CW-1:0] coef_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [AW-1:0] data_out
);

  typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

  state_e state_q, state_d;

  logic [DW-1:0] hist_q [NTAPS];
  logic [CW-1:0] coef_q [NTAPS];
  logic [KW-1:0] wr_ptr_q;
  logic [KW-1:0] k_q;
  logic [AW-1:0] acc_q;

  logic                   accept;
  logic                   mac_step;
  logic                   last_tap;
  logic                   coef_wr;
  logic [KW-1:0]          rd_idx;
  logic signed [DW+CW-1:0] prod;

  assign accept   = in_ready_o & in_valid_i;
  assign mac_step = (state_q == StMac) & en_i;
  assign last_tap = (k_q == KW'(NTAPS - 1));
  assign coef_wr  = coef_we_i & (state_q == StIdle) & (32'(coef_addr_i) < NTAPS);

  // History read index (wr_ptr - k) mod NTAPS; NTAPS need not be a power of two.
  always_comb begin
    if (k_q <= wr_ptr_q) begin
      rd_idx = wr_ptr_q - k_q;
    end else begin
      rd_idx = KW'(NTAPS) + wr_ptr_q - k_q;
    end
  end

  // Signed DW x CW product of the current tap.
  always_comb begin
    prod = $signed(coef_q[k_q]) * $signed(hist_q[rd_idx]);
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the output handshake is deliberately not gated by en_i.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StMac;
      StMac:  if (mac_step && last_tap) state_d = StOut;
      StOut:  if (out_ready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    in_ready_o  = (state_q == StIdle) & en_i;
    out_valid_o = (state_q == StOut);
    data_out    = out_valid_o ? acc_q : '0;
  end

  // Datapath: coefficient bank, history buffer, tap counter and accumulator.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NTAPS; i++) begin
        hist_q[i] <= '0;
        coef_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      k_q      <= '0;
      acc_q    <= '0;
    end else begin
      if (coef_wr) begin
        coef_q[coef_addr_i] <= coef_data_i;
      end
      if (accept) begin
        hist_q[wr_ptr_q] <= data_in;
        acc_q            <= '0;
        k_q              <= '0;
      end else if (mac_step) begin
        acc_q <= acc_q + {{(AW - DW - CW){prod[DW+CW-1]}}, prod};
        k_q   <= k_q + 1'b1;
        // Pointer moves only after the newest sample has been used at k=0.
        if (last_tap) begin
          wr_ptr_q <= (wr_ptr_q == KW'(NTAPS - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_serial_mac.sv
// Directed bench for fir_serial_mac with hand-computed expected outputs.
module tb_fir_serial_mac;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] data_in;
  logic        coef_we;
  logic [2:0]  coef_addr;
  logic [15:0] coef_data;
  logic        out_valid;
  logic        out_ready;
  logic [34:0] data_out;

  int n_tests = 0;
  int n_fail  = 0;

  fir_serial_mac dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .en_i        (en),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .data_in     (data_in),
    .coef_we_i   (coef_we),
    .coef_addr_i (coef_addr),
    .coef_data_i (coef_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .data_out    (data_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic signed [63:0] got,
                          input logic signed [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic write_coef(input logic [2:0] addr, input logic [15:0] val);
    coef_we   = 1'b1;
    coef_addr = addr;
    coef_data = val;
    @(negedge clk);
    coef_we   = 1'b0;
  endtask

  // Offer one sample from IDLE, optionally stall en mid-MAC (with an ignored
  // coefficient write) and optionally hold off the output handshake.
  task automatic run_sample(input string tag, input logic [15:0] x,
                            input logic signed [63:0] exp, input int hold,
                            input int stall_len);
    int          cyc;
    logic [34:0] held;
    check_eq({tag, "_rdy"}, in_ready, 1);
    in_valid = 1'b1;
    data_in  = x;
    @(negedge clk);
    in_valid = 1'b0;
    data_in  = '0;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      if (stall_len > 0 && cyc == 3) begin
        en        = 1'b0;
        coef_we   = 1'b1;
        coef_addr = 3'd0;
        coef_data = 16'd99;
      end
      if (stall_len > 0 && cyc == 3 + stall_len) begin
        en      = 1'b1;
        coef_we = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    en      = 1'b1;
    coef_we = 1'b0;
    check_eq({tag, "_lat"}, cyc, 8 + stall_len);
    check_eq({tag, "_data"}, $signed(data_out), exp);
    if (hold > 0) begin
      out_ready = 1'b0;
      held      = data_out;
      repeat (hold) begin
        in_valid = 1'b1;
        data_in  = 16'h7fff;
        @(negedge clk);
        check_eq({tag, "_bp_vld"}, out_valid, 1);
        check_eq({tag, "_bp_data"}, data_out, held);
        check_eq({tag, "_bp_rdy"}, in_ready, 0);
      end
      in_valid  = 1'b0;
      data_in   = '0;
      out_ready = 1'b1;
    end
    @(negedge clk);
    check_eq({tag, "_done"}, out_valid, 0);
  endtask

  initial begin
    int                 imp_exp [9];
    int                 step_exp [9];
    int                 cnt;
    logic signed [63:0] e;

    imp_exp  = '{1, 2, 3, 4, 5, 6, 7, 8, 0};
    step_exp = '{1, 3, 6, 10, 15, 21, 28, 36, 36};

    clk       = 1'b0;
    rst_n     = 1'b0;
    en        = 1'b1;
    in_valid  = 1'b0;
    data_in   = '0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    out_ready = 1'b1;

    #1;
    check_eq("rst_vld", out_valid, 0);
    check_eq("rst_data", data_out, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_rdy", in_ready, 1);

    // c[k] = k+1
    for (int k = 0; k < 8; k++) write_coef(3'(k), 16'(k + 1));

    for (int i = 0; i < 9; i++) begin
      run_sample($sformatf("imp%0d", i), (i == 0) ? 16'd1 : 16'd0, imp_exp[i], 0, 0);
    end

    // Step response; backpressure on sample 2, enable stall on sample 4.
    for (int i = 0; i < 9; i++) begin
      run_sample($sformatf("step%0d", i), 16'd1, step_exp[i],
                 (i == 2) ? 5 : 0, (i == 4) ? 3 : 0);
    end

    // Extremes: history holds eight 1s, replaced one by one with -32768.
    for (int k = 0; k < 8; k++) write_coef(3'(k), 16'h8000);
    for (int i = 1; i <= 8; i++) begin
      e = -64'sd32768 * (64'(i) * -64'sd32768 + 64'(8 - i));
      run_sample($sformatf("ext%0d", i), 16'h8000, e, 0, 0);
    end
    check_eq("ext_final", $signed(data_out), 0);

    // Reset in the middle of MAC, at k=4.
    in_valid = 1'b1;
    data_in  = 16'd1;
    @(negedge clk);
    in_valid = 1'b0;
    data_in  = '0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mrst_vld", out_valid, 0);
    check_eq("mrst_data", data_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check_eq("mrst_no_out", cnt, 0);
    run_sample("post_rst", 16'd1, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
